gun_controller: RTL

GUN_CONTROLLER -- requirements
Module: gun_controller

---
 rtl/gun_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gun_controller.sv
// Light-gun shot sequencer: debounces the trigger, flashes a black frame then a
// target frame, and grades the shot from what the photodetector saw in each.
module gun_controller #(
   parameter int DEBOUNCE_CYCLES = 65000,
   parameter int AMMO_MAX        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       enable,
   input  logic       reload,
   input  logic       trigger_raw,
   input  logic       photodetector_raw,
   output logic       flash_black,
   output logic       flash_target,
   output logic       hit,
   output logic       miss,
   output logic       busy,
   output logic [1:0] ammo
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      BLACK,
      TARGET,
      RESULT
   } state_t;

   localparam int             CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]     AMMO_FULL = 2'(AMMO_MAX);

   state_t           state;
   logic             trig_meta;
   logic             trig_sync;
   logic             pd_meta;
   logic             pd_sync;
   logic [1:0]       sync_fill;
   logic             deb_level;
   logic             deb_rise;
   logic [CNT_W-1:0] deb_cnt;
   logic             hold_block;
   logic             dark_light;
   logic             target_light;
   logic             shot_req;
   logic             accept;
   logic             target_seen;

   // Two-flop synchronizers; sync_fill marks when trig_sync carries real input
   // rather than the reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_meta <= 1'b0;
         trig_sync <= 1'b0;
         pd_meta   <= 1'b0;
         pd_sync   <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         trig_meta <= trigger_raw;
         trig_sync <= trig_meta;
         pd_meta   <= photodetector_raw;
         pd_sync   <= pd_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // Debounce: the accepted level follows the synchronized trigger only after
   // it has disagreed for DEBOUNCE_CYCLES cycles in a row. hold_block swallows
   // presses until the trigger has been seen released after reset, so a trigger
   // held through reset cannot fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_level  <= 1'b0;
         deb_cnt    <= '0;
         deb_rise   <= 1'b0;
         hold_block <= 1'b1;
      end else begin
         deb_rise <= 1'b0;
         if (trig_sync != deb_level) begin
            if (deb_cnt == CNT_LAST) begin
               deb_level <= trig_sync;
               deb_cnt   <= '0;
               deb_rise  <= trig_sync;
            end else begin
               deb_cnt <= deb_cnt + CNT_W'(1);
            end
         end else begin
            deb_cnt <= '0;
         end
         if (sync_fill[1] && !trig_sync && !deb_level) begin
            hold_block <= 1'b0;
         end
      end
   end

   assign shot_req    = deb_rise && !hold_block;
   assign accept      = (state == IDLE) && shot_req && enable && (ammo != 2'd0);
   assign target_seen = target_light || pd_sync;

   // Shot sequencer with registered outputs: each transition also sets the
   // outputs that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dark_light   <= 1'b0;
         target_light <= 1'b0;
         flash_black  <= 1'b0;
         flash_target <= 1'b0;
         hit          <= 1'b0;
         miss         <= 1'b0;
         busy         <= 1'b0;
         ammo         <= AMMO_FULL;
      end else begin
         hit  <= 1'b0;
         miss <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state        <= ARM;
                  busy         <= 1'b1;
                  dark_light   <= 1'b0;
                  target_light <= 1'b0;
               end
            end
            ARM: begin
               if (frame_start) begin
                  state       <= BLACK;
                  flash_black <= 1'b1;
               end
            end
            BLACK: begin
               dark_light <= dark_light || pd_sync;
               if (frame_start) begin
                  state        <= TARGET;
                  flash_black  <= 1'b0;
                  flash_target <= 1'b1;
               end
            end
            TARGET: begin
               target_light <= target_seen;
               if (frame_start) begin
                  state        <= RESULT;
                  flash_target <= 1'b0;
                  hit          <= target_seen && !dark_light;
                  miss         <= !(target_seen && !dark_light);
               end
            end
            RESULT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               flash_black  <= 1'b0;
               flash_target <= 1'b0;
            end
         endcase

         // Acceptance requires ammo != 0, so the decrement cannot wrap.
         if (reload) begin
            ammo <= accept ? (AMMO_FULL - 2'd1) : AMMO_FULL;
         end else if (accept) begin
            ammo <= ammo - 2'd1;
         end
      end
   end

endmodule
